// File: rtl/packet_pkg.sv
// Shared packet-path types and constants for the header filter and its neighbours.
package packet_pkg;
    typedef logic [47:0] mac_t;
    typedef logic [15:0] etype_t;

    localparam etype_t ETYPE_IPV4 = 16'h0800;
    localparam etype_t ETYPE_IPV6 = 16'h86DD;
    localparam mac_t   MAC_BCAST  = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } filter_state_e;
endpackage

// File: rtl/sat_counter.sv
// Statistics counter that stops at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/header_filter.sv
// Per-packet pass/drop filter on destination MAC and EtherType, one registered stage.
// Build option: HEADER_FILTER_BCAST_EN also accepts the broadcast destination.
module header_filter
    import packet_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter etype_t      ETYPE_0 = ETYPE_IPV4,
    parameter etype_t      ETYPE_1 = ETYPE_IPV6
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic [47:0]      iLocal_mac,
    input  logic [47:0]      iHeader_A,
    input  logic             iHeader_A_valid,
    input  logic [47:0]      iHeader_B,
    input  logic             iHeader_B_valid,
    input  logic [15:0]      iHeader_C,
    input  logic             iHeader_C_valid,
    input  logic [63:0]      iPayload,
    input  logic             iPayload_valid,
    input  logic             iSop,
    input  logic             iEop,
    input  logic [7:0]       iByte_enable,
    output logic [63:0]      oPayload,
    output logic             oPayload_valid,
    output logic             oSop,
    output logic             oEop,
    output logic [7:0]       oByte_enable,
    output logic [47:0]      oSrc_mac,
    output logic             oAbort,
    output logic [CNT_W-1:0] oPass_count,
    output logic [CNT_W-1:0] oDrop_count,
    output logic [CNT_W-1:0] oError_count
);
    filter_state_e state_q, state_d;
    mac_t          a_q, b_q;
    etype_t        c_q;
    logic          a_seen_q, b_seen_q, c_seen_q;
    logic          err_q, err_d;

    logic   decide, cap_en, a_take, b_take, c_take, all_seen, a_ok, c_ok;
    mac_t   a_cur, b_cur;
    etype_t c_cur;
    logic   fwd, pass_inc, drop_inc, err_inc, abort_d, seen_clr, src_ld;

    assign decide = iPayload_valid & iSop;
    assign cap_en = (state_q == IDLE) | decide;
    assign a_take = iHeader_A_valid & cap_en;
    assign b_take = iHeader_B_valid & cap_en;
    assign c_take = iHeader_C_valid & cap_en;

    // Same-cycle header writes take part in the decision.
    assign a_cur    = a_take ? iHeader_A : a_q;
    assign b_cur    = b_take ? iHeader_B : b_q;
    assign c_cur    = c_take ? iHeader_C : c_q;
    assign all_seen = (a_seen_q | a_take) & (b_seen_q | b_take) & (c_seen_q | c_take);

`ifdef HEADER_FILTER_BCAST_EN
    assign a_ok = (a_cur == iLocal_mac) || (a_cur == MAC_BCAST);
`else
    assign a_ok = (a_cur == iLocal_mac);
`endif
    assign c_ok = (c_cur == ETYPE_0) || (c_cur == ETYPE_1);

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        fwd      = 1'b0;
        pass_inc = 1'b0;
        drop_inc = 1'b0;
        err_inc  = 1'b0;
        abort_d  = 1'b0;
        seen_clr = 1'b0;
        src_ld   = 1'b0;
        if (iPayload_valid) begin
            if (iSop) begin
                // A new sop abandons any open packet; that packet is never counted.
                abort_d  = (state_q == PASS);
                seen_clr = 1'b1;
                if (!all_seen) begin
                    err_inc = 1'b1;
                    err_d   = 1'b1;
                    state_d = DROP;
                end else if (a_ok && c_ok) begin
                    fwd      = 1'b1;
                    src_ld   = 1'b1;
                    pass_inc = iEop;
                    state_d  = PASS;
                end else begin
                    err_d    = 1'b0;
                    drop_inc = iEop;
                    state_d  = DROP;
                end
                if (iEop) state_d = IDLE;
            end else begin
                case (state_q)
                    PASS: begin
                        fwd = 1'b1;
                        if (iEop) begin
                            pass_inc = 1'b1;
                            seen_clr = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    DROP: begin
                        if (iEop) begin
                            drop_inc = !err_q;
                            seen_clr = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state_q  <= IDLE;
            err_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            a_seen_q <= 1'b0;
            b_seen_q <= 1'b0;
            c_seen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            a_q      <= a_cur;
            b_q      <= b_cur;
            c_q      <= c_cur;
            a_seen_q <= !seen_clr & (a_seen_q | a_take);
            b_seen_q <= !seen_clr & (b_seen_q | b_take);
            c_seen_q <= !seen_clr & (c_seen_q | c_take);
        end
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            oPayload       <= '0;
            oPayload_valid <= 1'b0;
            oSop           <= 1'b0;
            oEop           <= 1'b0;
            oByte_enable   <= '0;
            oSrc_mac       <= '0;
            oAbort         <= 1'b0;
        end else begin
            oPayload_valid <= fwd;
            oSop           <= fwd & iSop;
            oEop           <= fwd & iEop;
            oAbort         <= abort_d;
            if (fwd) begin
                oPayload     <= iPayload;
                oByte_enable <= iByte_enable;
            end
            if (src_ld) oSrc_mac <= b_cur;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk  (iClk),
        .rst_n(iReset),
        .inc  (pass_inc),
        .clr  (1'b0),
        .count(oPass_count)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk  (iClk),
        .rst_n(iReset),
        .inc  (drop_inc),
        .clr  (1'b0),
        .count(oDrop_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk  (iClk),
        .rst_n(iReset),
        .inc  (err_inc),
        .clr  (1'b0),
        .count(oError_count)
    );
endmodule

// File: tb/tb_header_filter.sv
// Directed bench for header_filter: pass, drop, broadcast, error, abort, saturation, reset.
module tb_header_filter;
    localparam logic [47:0] LMAC = 48'h0200_0000_0001;
    localparam logic [47:0] OMAC = 48'h0200_0000_0002;
    localparam logic [47:0] SRC1 = 48'h1122_3344_5566;
    localparam logic [47:0] SRC2 = 48'hA1B2_C3D4_E5F6;

    logic        iClk = 1'b0;
    logic        iReset;
    logic [47:0] iLocal_mac;
    logic [47:0] iHeader_A, iHeader_B;
    logic [15:0] iHeader_C;
    logic        iHeader_A_valid, iHeader_B_valid, iHeader_C_valid;
    logic [63:0] iPayload;
    logic        iPayload_valid, iSop, iEop;
    logic [7:0]  iByte_enable;
    logic [63:0] oPayload;
    logic        oPayload_valid, oSop, oEop, oAbort;
    logic [7:0]  oByte_enable;
    logic [47:0] oSrc_mac;
    logic [15:0] oPass_count, oDrop_count, oError_count;

    int vectors = 0;
    int miscompares = 0;
    int exp_pass = 0;
    int exp_drop = 0;
    int exp_err = 0;

    header_filter dut (
        .iClk           (iClk),
        .iReset         (iReset),
        .iLocal_mac     (iLocal_mac),
        .iHeader_A      (iHeader_A),
        .iHeader_A_valid(iHeader_A_valid),
        .iHeader_B      (iHeader_B),
        .iHeader_B_valid(iHeader_B_valid),
        .iHeader_C      (iHeader_C),
        .iHeader_C_valid(iHeader_C_valid),
        .iPayload       (iPayload),
        .iPayload_valid (iPayload_valid),
        .iSop           (iSop),
        .iEop           (iEop),
        .iByte_enable   (iByte_enable),
        .oPayload       (oPayload),
        .oPayload_valid (oPayload_valid),
        .oSop           (oSop),
        .oEop           (oEop),
        .oByte_enable   (oByte_enable),
        .oSrc_mac       (oSrc_mac),
        .oAbort         (oAbort),
        .oPass_count    (oPass_count),
        .oDrop_count    (oDrop_count),
        .oError_count   (oError_count)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, " pass_cnt"}, 64'(oPass_count), 64'(exp_pass));
        check({tag, " drop_cnt"}, 64'(oDrop_count), 64'(exp_drop));
        check({tag, " err_cnt"}, 64'(oError_count), 64'(exp_err));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic hdr(input logic [47:0] a, input logic av, input logic [47:0] b, input logic bv,
                       input logic [15:0] c, input logic cv);
        iHeader_A = a; iHeader_A_valid = av;
        iHeader_B = b; iHeader_B_valid = bv;
        iHeader_C = c; iHeader_C_valid = cv;
    endtask

    task automatic hdr_off();
        iHeader_A_valid = 1'b0;
        iHeader_B_valid = 1'b0;
        iHeader_C_valid = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic sop, input logic eop, input logic [7:0] be);
        iPayload = d; iPayload_valid = 1'b1; iSop = sop; iEop = eop; iByte_enable = be;
    endtask

    task automatic no_beat();
        iPayload_valid = 1'b0; iSop = 1'b0; iEop = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        int n;
        iReset = 1'b0;
        iLocal_mac = LMAC;
        hdr('0, 1'b0, '0, 1'b0, '0, 1'b0);
        iPayload = '0; iByte_enable = '0;
        no_beat();
        tick(); tick();
        check("rst valid", 64'(oPayload_valid), 64'd0);
        check("rst sop_eop_abort", 64'({oSop, oEop, oAbort}), 64'd0);
        check("rst data", oPayload, 64'd0);
        check("rst src", 64'(oSrc_mac), 64'd0);
        check_counts("rst");
        iReset = 1'b1;
        tick();

        // 5-beat passed packet, last beat has 3 bytes
        hdr(LMAC, 1'b1, SRC1, 1'b1, 16'h0800, 1'b1);
        tick();
        hdr_off();
        for (int i = 0; i < 5; i++) begin
            d = 64'h1000_0000_0000_0000 + 64'(i * 64'h0101);
            beat(d, i == 0, i == 4, (i == 4) ? 8'h07 : 8'hFF);
            tick();
            if (i == 4) exp_pass = 1;
            check($sformatf("p1 valid b%0d", i), 64'(oPayload_valid), 64'd1);
            check($sformatf("p1 data b%0d", i), oPayload, d);
            check($sformatf("p1 sop_eop b%0d", i), 64'({oSop, oEop}),
                  64'({i == 0, i == 4}));
            check($sformatf("p1 pass_cnt b%0d", i), 64'(oPass_count), 64'(exp_pass));
        end
        check("p1 be last", 64'(oByte_enable), 64'h07);
        check("p1 src", 64'(oSrc_mac), 64'(SRC1));
        no_beat();
        tick();
        check("gap valid", 64'(oPayload_valid), 64'd0);
        check("gap hold data", oPayload, 64'h1000_0000_0000_0404);
        check("gap sop_eop", 64'({oSop, oEop}), 64'd0);

        // Wrong destination: dropped
        hdr(OMAC, 1'b1, SRC2, 1'b1, 16'h0800, 1'b1);
        tick();
        hdr_off();
        for (int i = 0; i < 3; i++) begin
            beat(64'hDEAD_0000 + 64'(i), i == 0, i == 2, 8'hFF);
            tick();
            if (i == 2) exp_drop = 1;
            check($sformatf("p2 valid b%0d", i), 64'(oPayload_valid), 64'd0);
            check($sformatf("p2 drop_cnt b%0d", i), 64'(oDrop_count), 64'(exp_drop));
        end
        no_beat();
        tick();
        check_counts("p2");

        // Broadcast destination with IPv6
        hdr(48'hFFFF_FFFF_FFFF, 1'b1, SRC2, 1'b1, 16'h86DD, 1'b1);
        tick();
        hdr_off();
        beat(64'hB0B0_0000_0000_0001, 1'b1, 1'b0, 8'hFF);
        tick();
`ifdef HEADER_FILTER_BCAST_EN
        check("bc valid", 64'(oPayload_valid), 64'd1);
        exp_pass = exp_pass + 1;
`else
        check("bc valid", 64'(oPayload_valid), 64'd0);
        exp_drop = exp_drop + 1;
`endif
        beat(64'hB0B0_0000_0000_0002, 1'b0, 1'b1, 8'h0F);
        tick();
        no_beat();
        check_counts("bc");

        // EtherType never seen: error, not a drop
        hdr(LMAC, 1'b1, SRC1, 1'b1, 16'h0800, 1'b0);
        tick();
        hdr_off();
        beat(64'hE0E0, 1'b1, 1'b0, 8'hFF);
        tick();
        exp_err = 1;
        check("err valid sop", 64'(oPayload_valid), 64'd0);
        check_counts("err sop");
        beat(64'hE0E1, 1'b0, 1'b1, 8'hFF);
        tick();
        no_beat();
        check("err valid eop", 64'(oPayload_valid), 64'd0);
        check_counts("err eop");

        // Pass packet truncated by a new sop carrying same-cycle headers
        hdr(LMAC, 1'b1, SRC1, 1'b1, 16'h0800, 1'b1);
        tick();
        hdr_off();
        beat(64'hA000_0001, 1'b1, 1'b0, 8'hFF);
        tick();
        check("ab b1 abort", 64'(oAbort), 64'd0);
        beat(64'hA000_0002, 1'b0, 1'b0, 8'hFF);
        tick();
        check("ab b2 out", 64'({oPayload_valid, oAbort}), 64'b10);
        hdr(LMAC, 1'b1, SRC2, 1'b1, 16'h86DD, 1'b1);
        beat(64'hA000_0003, 1'b1, 1'b0, 8'hFF);
        tick();
        hdr_off();
        check("ab b3 abort", 64'(oAbort), 64'd1);
        check("ab b3 sop", 64'({oPayload_valid, oSop, oEop}), 64'b110);
        check("ab b3 src", 64'(oSrc_mac), 64'(SRC2));
        check_counts("ab b3");
        beat(64'hA000_0004, 1'b0, 1'b1, 8'h01);
        tick();
        no_beat();
        exp_pass = exp_pass + 1;
        check("ab b4 abort", 64'(oAbort), 64'd0);
        check("ab b4 eop", 64'({oPayload_valid, oEop}), 64'b11);
        check("ab b4 data", oPayload, 64'hA000_0004);
        check_counts("ab b4");

        // Saturate the drop counter with back-to-back single-beat drops
        n = 65535 - exp_drop;
        hdr(OMAC, 1'b1, SRC1, 1'b1, 16'h0800, 1'b1);
        beat(64'h5A5A, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < n; i++) tick();
        exp_drop = 65535;
        check("sat reach", 64'(oDrop_count), 64'hFFFF);
        check("sat valid", 64'(oPayload_valid), 64'd0);
        tick();
        check("sat hold", 64'(oDrop_count), 64'hFFFF);
        no_beat();
        hdr_off();
        tick();
        check_counts("sat");

        // Reset asserted in the middle of a passed packet
        hdr(LMAC, 1'b1, SRC1, 1'b1, 16'h0800, 1'b1);
        tick();
        hdr_off();
        beat(64'hC0C0_0001, 1'b1, 1'b0, 8'hFF);
        tick();
        check("mid valid", 64'(oPayload_valid), 64'd1);
        beat(64'hC0C0_0002, 1'b0, 1'b0, 8'hFF);
        #2;
        iReset = 1'b0;
        #1;
        exp_pass = 0; exp_drop = 0; exp_err = 0;
        check("arst valid", 64'(oPayload_valid), 64'd0);
        check("arst data", oPayload, 64'd0);
        check_counts("arst");
        tick();
        iReset = 1'b1;
        beat(64'hC0C0_0003, 1'b0, 1'b0, 8'hFF);
        tick();
        check("post rst orphan", 64'(oPayload_valid), 64'd0);
        beat(64'hC0C0_0004, 1'b0, 1'b1, 8'hFF);
        tick();
        check("post rst orphan eop", 64'(oPayload_valid), 64'd0);
        check_counts("post rst orphan");
        hdr(LMAC, 1'b1, SRC2, 1'b1, 16'h86DD, 1'b1);
        beat(64'hC0C0_0005, 1'b1, 1'b1, 8'h3F);
        tick();
        hdr_off();
        no_beat();
        exp_pass = 1;
        check("single beat out", 64'({oPayload_valid, oSop, oEop}), 64'b111);
        check("single beat be", 64'(oByte_enable), 64'h3F);
        check_counts("single beat");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/header_filter.md
# header_filter

Downstream stage of the payload aligner. Latches the per-packet destination MAC (header A), source MAC (header B) and EtherType (header C), then decides once per packet, on its first payload beat, whether to pass or drop the packet. Passed packets leave as the same 64-bit aligned payload stream with a single registered stage. Dropped packets are squashed entirely. Saturating pass, drop and error counters feed the status block.

## Interface
Parameters:
- CNT_W, 16, width of each statistics counter
- ETYPE_0, 16'h0800, first accepted EtherType
- ETYPE_1, 16'h86DD, second accepted EtherType

Ports:
- iClk  in  1  clock, rising edge
- iReset  in  1  asynchronous, active-low reset
- iLocal_mac  in  48  station MAC address; quasi-static, sampled on the decision beat
- iHeader_A / iHeader_A_valid  in  48/1  destination MAC
- iHeader_B / iHeader_B_valid  in  48/1  source MAC; captured for oSrc_mac only
- iHeader_C / iHeader_C_valid  in  16/1  EtherType
- iPayload / iPayload_valid  in  64/1  aligned payload beat
- iSop / iEop  in  1/1  first/last payload beat; qualified by iPayload_valid
- iByte_enable  in  8  valid bytes of the beat, LSB-first contiguous
- oPayload / oPayload_valid  out  64/1  filtered payload
- oSop / oEop / oByte_enable  out  1/1/8  filtered framing
- oSrc_mac  out  48  source MAC of the current passed packet, stable from oSop to oEop
- oAbort  out  1  one-cycle pulse: a passed packet was truncated by a new iSop
- oPass_count / oDrop_count / oError_count  out  CNT_W each  saturating counters

## Operation
- Header capture:
  - A header field is latched whenever its valid bit is high in IDLE, or in the same cycle as the decision beat. Each field sets its own seen flag.
  - If a valid bit repeats, the last write wins.
  - Seen flags clear on any accepted iEop beat and on the decision beat of the following packet.
- States:
  - IDLE: waiting for an iSop beat.
  - PASS: forwarding beats.
  - DROP: squashing beats.
- Decision on an IDLE beat with iPayload_valid & iSop. Header values include any same-cycle valid header.
  - a_ok = (A == iLocal_mac), or, with the broadcast option enabled, A == 48'hFFFF_FFFF_FFFF.
  - c_ok = (C == ETYPE_0) or (C == ETYPE_1).
  - If any seen flag is clear: go to DROP and increment oError_count (not oDrop_count).
  - Else if a_ok & c_ok: go to PASS and forward the beat.
  - Else: go to DROP.
- In PASS, forward every valid beat. In DROP, discard every valid beat.
- A beat with iEop closes the packet:
  - Return to IDLE.
  - Increment oPass_count or oDrop_count. Error packets are already counted.
  - A decision beat that also carries iEop is a single-beat packet: decided and closed in the same cycle.
- iSop arriving in PASS or DROP (missing eop):
  - The old packet is abandoned and this beat is decided as a new packet.
  - If the old packet was in PASS, assert oAbort. The old packet is counted in neither pass nor drop.
- iPayload_valid low: no state change. Beats in IDLE without iSop are discarded silently.
- Counters stop at all-ones. Addition is CNT_W wide with no wrap.

## Timing
- Latency is exactly one cycle, input beat to output beat. No backpressure; throughput is one beat per cycle.
- All outputs are registered.
- Reset values:
  - State IDLE, seen flags clear.
  - oPayload_valid, oSop, oEop, oAbort = 0.
  - oPayload, oByte_enable, oSrc_mac = 0.
  - All counters = 0.
- Output data holds its last value while oPayload_valid is low. oSop and oEop are only high together with oPayload_valid.
- Counters update on the cycle after the closing iEop beat, coincident with oEop for passed packets. oAbort coincides with the new packet's output oSop.
- Reset asserted mid-packet: outputs clear immediately (asynchronous). After release, beats are discarded until the next iSop.

## Configuration
- HEADER_FILTER_BCAST_EN:
  - Defined: a destination of 48'hFFFF_FFFF_FFFF also satisfies a_ok.
  - Undefined: only an exact iLocal_mac match passes. Broadcast frames are counted as drops.

## Structure
- packet_pkg gains:
  - typedef mac_t (48 bits) and etype_t (16 bits).
  - Constants ETYPE_IPV4 = 16'h0800, ETYPE_IPV6 = 16'h86DD, MAC_BCAST.
  - enum filter_state_e {IDLE, PASS, DROP}.
- One sub-module, sat_counter (parameter W; inputs inc and clr), instantiated three times.

## Test plan
- Local MAC 02:00:00:00:00:01, A matching, C = 0x0800, 5-beat payload -> identical 5 beats one cycle later; oPass_count = 1.
- A = 02:00:00:00:00:02 -> no output beats; oDrop_count = 1 the cycle after iEop.
- A = FF..FF, C = 0x86DD -> passes with HEADER_FILTER_BCAST_EN defined; dropped (oDrop_count = 1) without it.
- Header C never valid before iSop -> packet squashed; oError_count = 1; pass and drop counters unchanged.
- Passed packet, then new iSop at beat 3 with no iEop -> oAbort pulses alongside the new oSop; the new packet's decision is independent.
- Preload oDrop_count to 2^CNT_W−1 via 65535 drops with CNT_W = 16, then one more drop -> the counter stays 16'hFFFF; reset mid-packet clears all counters to 0.
